// File: rtl/key_search_ctrl.sv
// Brute-force key-search controller: steps a key range through an external decrypter
// and stops on the first plaintext made only of the selected printable characters.
module key_search_ctrl #(
  parameter int KEY_W      = 24,
  parameter int TEXT_BYTES = 16,
  parameter int DISP_W     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [KEY_W-1:0]        key_first,
  input  logic [KEY_W-1:0]        key_last,
  input  logic                    allow_lower,
  input  logic [8*TEXT_BYTES-1:0] dec_plaintext,
  input  logic                    dec_done,
  input  logic                    ddpt,
  output logic                    dec_enable,
  output logic [KEY_W-1:0]        key,
  output logic [DISP_W-1:0]       key_display,
  output logic [8*TEXT_BYTES-1:0] text_q,
  output logic                    time_go,
  output logic                    dpt,
  output logic                    busy,
  output logic                    found,
  output logic                    exhausted,
  output logic [KEY_W:0]          tries
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DECRYPT = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_DISPLAY = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]       state;
  logic [KEY_W-1:0] last_q;
  logic             lower_q;
  logic             text_ok;

  function automatic logic byte_ok(input logic [7:0] c, input logic lower);
    byte_ok = (c >= 8'h41 && c <= 8'h5A) ||
              (c >= 8'h30 && c <= 8'h39) ||
              (c == 8'h20) ||
              (lower && c >= 8'h61 && c <= 8'h7A);
  endfunction

  // Evaluated on the registered plaintext, so CHECK has no input-to-output path.
  always_comb begin
    text_ok = 1'b1;
    for (int i = 0; i < TEXT_BYTES; i++) begin
      if (!byte_ok(text_q[8*i +: 8], lower_q)) text_ok = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      key       <= '0;
      last_q    <= '0;
      lower_q   <= 1'b0;
      text_q    <= '0;
      tries     <= '0;
      found     <= 1'b0;
      exhausted <= 1'b0;
    end else if (abort && state != S_IDLE) begin
      state     <= S_IDLE;
      found     <= 1'b0;
      exhausted <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            key       <= key_first;
            last_q    <= key_last;
            lower_q   <= allow_lower;
            tries     <= '0;
            found     <= 1'b0;
            exhausted <= 1'b0;
            state     <= S_DECRYPT;
          end
        end
        S_DECRYPT: begin
          if (dec_done) begin
            text_q <= dec_plaintext;
            if (tries != '1) tries <= tries + (KEY_W+1)'(1);
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          // A match on the final key wins over exhaustion.
          if (text_ok) begin
            found <= 1'b1;
            state <= S_DISPLAY;
          end else if (key == last_q) begin
            exhausted <= 1'b1;
            state     <= S_DONE;
          end else begin
            key   <= key + KEY_W'(1);
            state <= S_DECRYPT;
          end
        end
        S_DISPLAY: begin
          if (ddpt) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dec_enable  = (state == S_DECRYPT);
  assign busy        = (state == S_DECRYPT) || (state == S_CHECK);
  assign time_go     = busy;
  assign dpt         = (state == S_DISPLAY);
  assign key_display = key[KEY_W-1 -: DISP_W];

endmodule

// File: tb/tb_key_search_ctrl.sv
// Randomized bench for key_search_ctrl with a range/plaintext reference model.
module tb_key_search_ctrl;
  localparam int KW = 24;
  localparam int TB = 16;
  localparam int DW = 16;
  localparam int TW = 8*TB;

  logic          clk = 1'b0;
  logic          reset, start, abort, allow_lower, dec_done, ddpt;
  logic [KW-1:0] key_first, key_last;
  logic [TW-1:0] dec_plaintext;
  logic          dec_enable, time_go, dpt, busy, found, exhausted;
  logic [KW-1:0] key;
  logic [DW-1:0] key_display;
  logic [TW-1:0] text_q;
  logic [KW:0]   tries;

  int checks = 0;
  int errors = 0;

  logic          plant_vld;
  logic [KW-1:0] plant_key;
  logic [TW-1:0] plant_text;
  logic          plant_ok;
  logic [TW-1:0] last_txt;

  localparam logic [TW-1:0] HELLO_UP = "HELLO WORLD 2024";
  localparam logic [TW-1:0] HELLO_LO = "hello world 2024";

  key_search_ctrl #(.KEY_W(KW), .TEXT_BYTES(TB), .DISP_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .key_first(key_first), .key_last(key_last), .allow_lower(allow_lower),
    .dec_plaintext(dec_plaintext), .dec_done(dec_done), .ddpt(ddpt),
    .dec_enable(dec_enable), .key(key), .key_display(key_display),
    .text_q(text_q), .time_go(time_go), .dpt(dpt), .busy(busy),
    .found(found), .exhausted(exhausted), .tries(tries)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [TW-1:0] good_text(input logic with_lower);
    logic [TW-1:0] t;
    int r, p;
    for (int i = 0; i < TB; i++) begin
      r = $urandom_range(0, 36);
      t[8*i +: 8] = (r < 26) ? 8'(8'h41 + r) : (r < 36) ? 8'(8'h30 + r - 26) : 8'h20;
    end
    if (with_lower) begin
      p = $urandom_range(0, TB-1);
      t[8*p +: 8] = 8'(8'h61 + $urandom_range(0, 25));
    end
    return t;
  endfunction

  // One character just outside every accepted range spoils an otherwise clean text.
  function automatic logic [TW-1:0] bad_text();
    logic [TW-1:0] t;
    logic [7:0] c;
    int p;
    t = good_text(1'($urandom_range(0, 1)));
    case ($urandom_range(0, 7))
      0: c = 8'h40;
      1: c = 8'h5B;
      2: c = 8'h2F;
      3: c = 8'h3A;
      4: c = 8'h60;
      5: c = 8'h7B;
      6: c = 8'h1F;
      default: c = 8'h21;
    endcase
    p = $urandom_range(0, TB-1);
    t[8*p +: 8] = c;
    return t;
  endfunction

  function automatic logic [TW-1:0] text_for(input logic [KW-1:0] k);
    if (plant_vld && k == plant_key) return plant_text;
    return bad_text();
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_dec_enable"}, TW'(dec_enable), TW'(0));
    check_val({tag, "_busy"}, TW'(busy), TW'(0));
    check_val({tag, "_time_go"}, TW'(time_go), TW'(0));
    check_val({tag, "_dpt"}, TW'(dpt), TW'(0));
  endtask

  task automatic run_search(input string tag, input logic [KW-1:0] first,
                            input logic [KW-1:0] last, input logic mode);
    logic [KW-1:0] span, exp_key;
    logic [TW-1:0] txt;
    int n_keys, d;
    logic hit;
    span   = last - first;
    n_keys = int'(span) + 1;
    key_first   = first;
    key_last    = last;
    allow_lower = mode;
    start = 1'b1;
    tick();
    start = 1'b0;
    key_first = KW'($urandom);
    key_last  = KW'($urandom);
    allow_lower = ~mode;
    check_val({tag, "_start_en"}, TW'(dec_enable), TW'(1));
    check_val({tag, "_start_tries"}, TW'(tries), TW'(0));
    check_val({tag, "_start_found"}, TW'({found, exhausted}), TW'(0));
    for (int i = 0; i < n_keys; i++) begin
      exp_key = first + KW'(i);
      d = $urandom_range(0, 3);
      repeat (d) tick();
      check_val({tag, "_key"}, TW'(key), TW'(exp_key));
      check_val({tag, "_key_display"}, TW'(key_display), TW'(exp_key[KW-1 -: DW]));
      check_val({tag, "_decrypt_en"}, TW'({dec_enable, busy, time_go}), TW'(3'b111));
      txt = text_for(exp_key);
      dec_plaintext = txt;
      dec_done = 1'b1;
      tick();
      dec_done = 1'b0;
      dec_plaintext = bad_text();
      last_txt = txt;
      check_val({tag, "_check_en_low"}, TW'({dec_enable, busy, time_go}), TW'(3'b011));
      check_val({tag, "_text_q"}, text_q, txt);
      check_val({tag, "_tries"}, TW'(tries), TW'(i + 1));
      tick();
      hit = plant_vld && plant_ok && (exp_key == plant_key);
      if (hit) begin
        check_val({tag, "_display"}, TW'({dpt, found, busy, dec_enable}), TW'(4'b1100));
        d = $urandom_range(0, 3);
        repeat (d) tick();
        check_val({tag, "_dpt_hold"}, TW'(dpt), TW'(1));
        ddpt = 1'b1;
        tick();
        ddpt = 1'b0;
        check_idle_outputs({tag, "_done"});
        check_val({tag, "_found"}, TW'({found, exhausted}), TW'(2'b10));
        check_val({tag, "_final_key"}, TW'(key), TW'(exp_key));
        check_val({tag, "_final_tries"}, TW'(tries), TW'(i + 1));
        break;
      end else if (i == n_keys - 1) begin
        check_idle_outputs({tag, "_exh"});
        check_val({tag, "_exhausted"}, TW'({found, exhausted}), TW'(2'b01));
        check_val({tag, "_final_key"}, TW'(key), TW'(exp_key));
        check_val({tag, "_final_tries"}, TW'(tries), TW'(n_keys));
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; allow_lower = 1'b0;
    dec_done = 1'b0; ddpt = 1'b0; key_first = '0; key_last = '0;
    dec_plaintext = '0; plant_vld = 1'b0; plant_key = '0;
    plant_text = '0; plant_ok = 1'b0; last_txt = '0;
    #2;
    check_idle_outputs("reset");
    check_val("reset_regs", TW'({key, tries, found, exhausted}), TW'(0));
    check_val("reset_text", text_q, TW'(0));
    tick();
    reset = 1'b0;
    tick();
    check_idle_outputs("idle");

    plant_vld = 1'b1; plant_key = 24'h000012; plant_text = HELLO_UP; plant_ok = 1'b1;
    run_search("t1", 24'h000010, 24'h000013, 1'b0);

    plant_vld = 1'b0;
    run_search("t2", 24'h000005, 24'h000005, 1'b0);
    repeat (3) tick();
    check_val("t2_single_pulse", TW'({dec_enable, exhausted}), TW'(2'b01));

    // Stray dec_done while DONE must not disturb the captured text.
    dec_plaintext = HELLO_UP;
    dec_done = 1'b1;
    tick();
    dec_done = 1'b0;
    check_val("done_ignore_text", text_q, last_txt);
    check_idle_outputs("done_ignore");

    run_search("t3", 24'hFFFFFE, 24'h000001, 1'b0);

    plant_vld = 1'b1; plant_key = 24'h00ABCD; plant_text = HELLO_LO; plant_ok = 1'b0;
    run_search("t4a", 24'h00ABCD, 24'h00ABCD, 1'b0);
    plant_ok = 1'b1;
    run_search("t4b", 24'h00ABCC, 24'h00ABCE, 1'b1);

    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check_idle_outputs("abort_done");
    check_val("abort_done_flags", TW'({found, exhausted}), TW'(0));

    plant_vld = 1'b0;
    key_first = 24'h000100; key_last = 24'h000105;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    dec_plaintext = HELLO_UP;
    dec_done = 1'b1;
    abort = 1'b1;
    tick();
    dec_done = 1'b0;
    abort = 1'b0;
    check_idle_outputs("t5_abort");
    check_val("t5_abort_flags", TW'({found, exhausted}), TW'(0));
    check_val("t5_abort_text", text_q, last_txt);
    check_val("t5_abort_key", TW'(key), TW'(24'h000100));
    check_val("t5_abort_tries", TW'(tries), TW'(0));
    tick();
    check_idle_outputs("t5_stays_idle");

    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("t5_pre_reset_en", TW'(dec_enable), TW'(1));
    #1 reset = 1'b1;
    #1;
    check_idle_outputs("t5_async_reset");
    check_val("t5_async_regs", TW'({key, tries, found, exhausted}), TW'(0));
    check_val("t5_async_text", text_q, TW'(0));
    tick();
    reset = 1'b0;
    tick();

    for (int r = 0; r < 24; r++) begin
      logic [KW-1:0] first;
      logic mode;
      int len, kind, off;
      len   = $urandom_range(1, 6);
      first = ($urandom_range(0, 2) == 0) ? KW'(24'hFFFFFF - $urandom_range(0, 3)) : KW'($urandom);
      mode  = 1'($urandom_range(0, 1));
      kind  = $urandom_range(0, 2);
      off   = $urandom_range(0, len - 1);
      plant_vld  = (kind != 0);
      plant_key  = first + KW'(off);
      plant_text = good_text(kind == 2);
      plant_ok   = (kind == 1) || mode;
      run_search("rnd", first, first + KW'(len - 1), mode);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
